// File: rtl/datactl_bus.sv
// Parametrised tri-state data-bus write driver.
// One word per handshake; drive on grant for HOLD_CYC, then TURN_CYC idle.
module datactl_bus #(
  parameter int WIDTH    = 8,
  parameter int HOLD_CYC = 2,
  parameter int TURN_CYC = 1,
  parameter int CNT_W    = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             bus_grant,
  output wire  [WIDTH-1:0] data_bus,
  output logic             bus_oe,
  output logic             wr_done,
  output logic             retry
);

  typedef enum logic [1:0] {
    IDLE,
    WAIT_GNT,
    DRIVE,
    TURN
  } state_t;

  localparam logic [CNT_W-1:0] HOLD_LD =
    CNT_W'(HOLD_CYC - 1);
  localparam logic [CNT_W-1:0] TURN_LD =
    CNT_W'((TURN_CYC > 0) ? TURN_CYC - 1 : 0);

  state_t           state_q, state_d;
  logic [WIDTH-1:0] data_q, data_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             done_q, done_d;
  logic             retry_q, retry_d;
  logic             rst_seen_q, rst_seen_d;

  // Block accepts only once reset has been low for a full edge.
  assign in_ready = (state_q == IDLE) && !rst_seen_q;
  assign bus_oe   = (state_q == DRIVE);
  assign data_bus = bus_oe ? data_q : {WIDTH{1'bz}};
  assign wr_done  = done_q;
  assign retry    = retry_q;

  always_comb begin
    state_d    = state_q;
    data_d     = data_q;
    cnt_d      = cnt_q;
    done_d     = 1'b0;
    retry_d    = 1'b0;
    rst_seen_d = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (in_valid && in_ready) begin
          data_d  = in_data;
          state_d = WAIT_GNT;
        end
      end
      WAIT_GNT: begin
        if (bus_grant) begin
          cnt_d   = HOLD_LD;
          state_d = DRIVE;
        end
      end
      DRIVE: begin
        if (!bus_grant) begin
          retry_d = 1'b1;
          state_d = WAIT_GNT;
        end else if (cnt_q == '0) begin
          done_d = 1'b1;
          if (TURN_CYC > 0) begin
            cnt_d   = TURN_LD;
            state_d = TURN;
          end else begin
            state_d = IDLE;
          end
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      TURN: begin
        if (cnt_q == '0) state_d = IDLE;
        else cnt_d = cnt_q - 1'b1;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      data_q     <= '0;
      cnt_q      <= '0;
      done_q     <= 1'b0;
      retry_q    <= 1'b0;
      rst_seen_q <= 1'b1;
    end else begin
      state_q    <= state_d;
      data_q     <= data_d;
      cnt_q      <= cnt_d;
      done_q     <= done_d;
      retry_q    <= retry_d;
      rst_seen_q <= rst_seen_d;
    end
  end

endmodule

// File: tb/tb_datactl_bus.sv
// Scoreboard bench for datactl_bus: three configurations share stimulus,
// a transaction-level model predicts each cycle's outputs.
module tb_datactl_bus;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [15:0] in_data = 16'h0;
  logic        in_valid = 1'b0;
  logic        bus_grant = 1'b0;

  logic [2:0]  rdy, oe, done, rty;
  wire  [7:0]  bus0;
  wire  [15:0] bus1;
  wire  [7:0]  bus2;

  always #5 clk = ~clk;

  datactl_bus #(.WIDTH(8), .HOLD_CYC(2), .TURN_CYC(1), .CNT_W(4)) u0 (
    .clk(clk), .rst(rst), .in_data(in_data[7:0]), .in_valid(in_valid),
    .in_ready(rdy[0]), .bus_grant(bus_grant), .data_bus(bus0),
    .bus_oe(oe[0]), .wr_done(done[0]), .retry(rty[0]));

  datactl_bus #(.WIDTH(16), .HOLD_CYC(1), .TURN_CYC(0), .CNT_W(4)) u1 (
    .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid),
    .in_ready(rdy[1]), .bus_grant(bus_grant), .data_bus(bus1),
    .bus_oe(oe[1]), .wr_done(done[1]), .retry(rty[1]));

  datactl_bus #(.WIDTH(8), .HOLD_CYC(3), .TURN_CYC(2), .CNT_W(4)) u2 (
    .clk(clk), .rst(rst), .in_data(in_data[7:0]), .in_valid(in_valid),
    .in_ready(rdy[2]), .bus_grant(bus_grant), .data_bus(bus2),
    .bus_oe(oe[2]), .wr_done(done[2]), .retry(rty[2]));

  typedef struct packed {
    logic        rdy;
    logic        oe;
    logic        done;
    logic        rty;
    logic [15:0] data;
  } snap_t;

  snap_t exp_q [3][$];

  int hold_c [3] = '{2, 1, 3};
  int turn_c [3] = '{1, 0, 2};
  logic [15:0] mask_c [3] = '{16'h00FF, 16'hFFFF, 16'h00FF};

  // Model: a write is "pending" until it is driven for hold_c granted
  // cycles in a row; any ungranted drive edge restarts the count.
  bit          m_pending [3];
  bit          m_driving [3];
  bit          m_fresh   [3];
  int          m_left    [3];
  int          m_quiet   [3];
  logic [15:0] m_word    [3];
  bit          m_done    [3];
  bit          m_rty     [3];
  bit          started = 0;

  int passed = 0;
  int total  = 0;

  task automatic chk(input string name, input bit ok);
    total++;
    if (ok) passed++;
    else $display("FAIL %s t=%0t", name, $time);
  endtask

  initial begin : model
    forever begin
      @(posedge clk);
      if (rst) started = 1;
      if (started) begin
        for (int i = 0; i < 3; i++) begin
          bit can_take;
          snap_t s;
          can_take = !m_pending[i] && m_quiet[i] == 0 && !m_fresh[i];
          m_done[i] = 0;
          m_rty[i]  = 0;
          if (rst) begin
            m_pending[i] = 0;
            m_driving[i] = 0;
            m_quiet[i]   = 0;
            m_fresh[i]   = 1;
          end else begin
            m_fresh[i] = 0;
            if (m_quiet[i] > 0) begin
              m_quiet[i]--;
            end else if (m_driving[i]) begin
              if (!bus_grant) begin
                m_driving[i] = 0;
                m_rty[i] = 1;
              end else if (m_left[i] == 1) begin
                m_driving[i] = 0;
                m_pending[i] = 0;
                m_done[i] = 1;
                m_quiet[i] = turn_c[i];
              end else begin
                m_left[i]--;
              end
            end else if (m_pending[i]) begin
              if (bus_grant) begin
                m_driving[i] = 1;
                m_left[i] = hold_c[i];
              end
            end else if (can_take && in_valid) begin
              m_pending[i] = 1;
              m_word[i] = in_data & mask_c[i];
            end
          end
          s.rdy  = !m_pending[i] && m_quiet[i] == 0 && !m_fresh[i];
          s.oe   = m_driving[i];
          s.done = m_done[i];
          s.rty  = m_rty[i];
          s.data = m_driving[i] ? m_word[i] : 16'h0;
          exp_q[i].push_back(s);
        end
      end
    end
  end

  initial begin : monitor
    forever begin
      @(negedge clk);
      for (int i = 0; i < 3; i++) begin
        if (exp_q[i].size() > 0) begin
          snap_t e, a;
          e = exp_q[i].pop_front();
          a.rdy  = rdy[i];
          a.oe   = oe[i];
          a.done = done[i];
          a.rty  = rty[i];
          a.data = 16'h0;
          if (oe[i]) begin
            if (i == 0) a.data = {8'h0, bus0};
            else if (i == 1) a.data = bus1;
            else a.data = {8'h0, bus2};
          end
          total++;
          if (a === e) passed++;
          else
            $display("FAIL cfg%0d t=%0t rdy/oe/done/retry/data got %b%b%b%b/%h want %b%b%b%b/%h",
                     i, $time, a.rdy, a.oe, a.done, a.rty, a.data,
                     e.rdy, e.oe, e.done, e.rty, e.data);
        end
      end
    end
  end

  initial begin : watchdog
    #200000;
    chk("timeout", 1'b0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

  task automatic cyc(input int n = 1);
    repeat (n) @(negedge clk);
  endtask

  task automatic put(input logic [15:0] d, input logic v, input logic g);
    in_data = d;
    in_valid = v;
    bus_grant = g;
  endtask

  initial begin : stim
    put(16'h00A5, 1'b1, 1'b0);
    rst = 1'b1;
    cyc(3);
    chk("reset oe", oe === 3'b000);
    chk("reset bus0 z", bus0 === 8'hzz);
    chk("reset bus1 z", bus1 === 16'hzzzz);
    chk("reset bus2 z", bus2 === 8'hzz);
    chk("reset rdy", rdy === 3'b000);
    chk("reset done", done === 3'b000);
    chk("reset retry", rty === 3'b000);
    rst = 1'b0;
    put(16'h0000, 1'b0, 1'b0);
    cyc(1);

    put(16'h003C, 1'b1, 1'b1);
    cyc(1);
    in_valid = 1'b0;
    cyc(8);

    put(16'h0081, 1'b1, 1'b0);
    cyc(1);
    in_valid = 1'b0;
    cyc(5);
    chk("wait expired bus0 z", bus0 === 8'hzz);
    chk("wait expired oe0", oe[0] === 1'b0);
    bus_grant = 1'b1;
    cyc(8);

    put(16'h00C3, 1'b1, 1'b1);
    cyc(1);
    in_valid = 1'b0;
    cyc(1);
    bus_grant = 1'b0;
    cyc(2);
    bus_grant = 1'b1;
    cyc(10);

    put(16'h1234, 1'b1, 1'b1);
    cyc(3);
    in_data = 16'hBEEF;
    cyc(3);
    in_valid = 1'b0;
    cyc(8);

    put(16'h0055, 1'b1, 1'b1);
    cyc(1);
    in_valid = 1'b0;
    cyc(2);
    rst = 1'b1;
    cyc(1);
    rst = 1'b0;
    cyc(1);
    put(16'h00AA, 1'b1, 1'b1);
    cyc(1);
    in_valid = 1'b0;
    cyc(10);

    repeat (600) begin
      rst       = ($urandom_range(0, 99) == 0);
      in_valid  = ($urandom_range(0, 4) < 3);
      bus_grant = ($urandom_range(0, 3) != 0);
      in_data   = 16'($urandom);
      cyc(1);
    end
    rst = 1'b0;
    put(16'h0000, 1'b0, 1'b1);
    cyc(20);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
